hd44780_responder: RTL and testbench
====================================

# hd44780_responder

Synthesizable HD44780-compatible display controller model: the receiving end of the 8-bit parallel LCD bus (RS/EN/DATA) that our LCD host driver transmits on. It samples host writes, decodes the instruction set used by the host (clear, home, entry mode, display control, function set, set DDRAM address, data write) and keeps a 2x16 visible DDRAM image. It enforces busy timing and flags protocol violations. It sits in loopback benches and on-FPGA self-test builds so host output can be checked without a physical panel.

## Interface
Parameters:
- T_SHORT, 3700: busy duration in clk cycles for ordinary instructions and data writes (37 us at 100 MHz).
- T_LONG, 152000: busy duration in clk cycles for clear display and return home (1.52 ms at 100 MHz).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  reset, synchronous, active-low.
- RS  in  1  register select from host: 0 instruction, 1 data. Asynchronous to clk.
- EN  in  1  enable strobe from host; write is committed on its falling edge. Asynchronous to clk.
- DATA  in  8  bus data from host. Asynchronous to clk.
- row0  out  128  visible row 0, DDRAM 0x00-0x0F; column 0 in [127:120], column 15 in [7:0].
- row1  out  128  visible row 1, DDRAM 0x40-0x4F; same packing as row0.
- addr  out  7  address counter (AC).
- busy  out  1  high while an accepted write is executing.
- disp_on, cursor_on, blink_on  out  1 each  display control flags.
- two_line  out  1  function set N bit.
- inc_mode, shift_mode  out  1 each  entry mode I/D and S bits; shift_mode is reported only and does not alter row0/row1.
- wr_strobe  out  1  one-cycle pulse per accepted write.
- err_busy  out  1  sticky: a write arrived while busy.
- err_mode  out  1  sticky: function set received with DL=0 (4-bit mode unsupported).

## Operation
- RS, EN and DATA each pass through a 2-flop synchronizer. The falling edge of the synchronized EN is a write event, and the synchronized RS and DATA are captured at that edge.
- Write event while busy=1: discarded with no state change and no wr_strobe; err_busy is set.
- Write event while busy=0: accepted. wr_strobe pulses and the write is decoded as follows:
- RS=1, data write: DDRAM[AC] <= DATA if AC is in 0x00-0x0F or 0x40-0x4F; otherwise the data is dropped. AC is then stepped. Busy is T_SHORT.
- RS=0, instruction write, decoded by the highest set bit of DATA:
  - 0x00, no-op: no busy, no state change, but wr_strobe still pulses.
  - 0x01, clear: all 32 visible cells <= 0x20, AC <= 0, inc_mode <= 1. Busy is T_LONG.
  - 0x02/0x03, home: AC <= 0. Busy is T_LONG.
  - 0x04-0x07, entry mode: inc_mode <= D[1], shift_mode <= D[0]. Busy is T_SHORT.
  - 0x08-0x0F, display control: disp_on <= D[2], cursor_on <= D[1], blink_on <= D[0]. Busy is T_SHORT.
  - 0x10-0x1F, cursor/display shift: AC is stepped in direction D[2] only when D[3]=0. Busy is T_SHORT.
  - 0x20-0x3F, function set: two_line <= D[3]; err_mode is set if D[4]=0. Busy is T_SHORT.
  - 0x40-0x7F, set CGRAM address: ignored, but busy is T_SHORT.
  - 0x80-0xFF, set DDRAM address: AC <= D[6:0], loaded unmodified. Busy is T_SHORT.
- AC step, increment: 0x27 -> 0x40, 0x67 -> 0x00, any other value +1 modulo 128.
- AC step, decrement: 0x40 -> 0x27, 0x00 -> 0x67, any other value -1 modulo 128.
- Busy counter: loaded with T_SHORT-1 or T_LONG-1 on accept, decrements each cycle, and busy drops when it passes 0. Busy is therefore high for exactly T cycles.
- Reset values:
  - All cells 0x20, so row0 and row1 are 128'h2020...20.
  - addr=0, busy=0, wr_strobe=0.
  - disp_on=0, cursor_on=0, blink_on=0, two_line=0.
  - inc_mode=1, shift_mode=0.
  - err_busy=0, err_mode=0.
  - Synchronizer flops are cleared, so EN is seen as low after reset.
- Reset mid-busy or mid-strobe: everything returns to the reset values on that edge. A falling EN already in the synchronizer is lost.
- Error flags are cleared only by reset.

## Timing
- Host pin EN falls between clk edges E-1 and E. The write event is detected at edge E+2. Decode and all register updates (row0/row1, addr, flags) land at edge E+2, and wr_strobe and busy are high from E+2.
- RS and DATA must be stable at least 3 clk cycles before and 1 cycle after EN falls. The host holds them for its whole step, which satisfies this.
- Minimum EN high and low widths are each 3 clk cycles. Narrower pulses may be missed, and no error is raised for them.
- The first write accepted after busy drops is the one detected on the cycle busy reads 0.
- A falling EN detected on the same edge that busy clears is accepted.

## Test plan
Bench uses T_SHORT=8 and T_LONG=40, with EN pulses 40 cycles wide.
- Reset, then send 0x38, 0x0C, 0x01, 0x06 with a 50-cycle gap each -> two_line=1, disp_on=1, cursor_on=0, inc_mode=1, no errors, row0/row1 all 0x20.
- Send 0x80, then data "HELLO" -> row0[127:88]=48 45 4C 4C 4F, addr=0x05. Then send 0xC0 and "A" -> row1[127:120]=0x41, addr=0x41.
- Send 0xA7 (AC=0x27), then data 0x58 -> no visible change and addr=0x40. Send 0x04 (decrement), then data 0x59 -> row1 col0=0x59 and addr=0x27.
- Send 0x01, then a second write 10 cycles after the first is detected -> second write ignored, err_busy=1, busy high for exactly 40 cycles.
- Send 0x28 -> err_mode=1 and two_line=1. Assert reset_n=0 for 1 cycle while busy -> every output returns to its reset value.
- Host driver instance in loopback with row0="0123456789ABCDEF" -> after the first refresh, row0 matches exactly and err_busy stays 0.

Source files
------------

// File: rtl/hd44780_responder.sv
// HD44780-compatible receiver for the 8-bit RS/EN/DATA LCD bus.
// Decodes host writes into a 2x16 DDRAM image and enforces busy timing.
module hd44780_responder #(
  parameter int T_SHORT = 3700,
  parameter int T_LONG  = 152000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         RS,
  input  logic         EN,
  input  logic [7:0]   DATA,
  output logic [127:0] row0,
  output logic [127:0] row1,
  output logic [6:0]   addr,
  output logic         busy,
  output logic         disp_on,
  output logic         cursor_on,
  output logic         blink_on,
  output logic         two_line,
  output logic         inc_mode,
  output logic         shift_mode,
  output logic         wr_strobe,
  output logic         err_busy,
  output logic         err_mode
);

  localparam int T_MAX = (T_LONG > T_SHORT) ? T_LONG : T_SHORT;
  localparam int CW    = $clog2(T_MAX) + 1;
  localparam logic [CW-1:0] LOAD_SHORT = CW'(T_SHORT - 1);
  localparam logic [CW-1:0] LOAD_LONG  = CW'(T_LONG - 1);
  localparam logic [127:0]  BLANK_ROW  = {16{8'h20}};

  localparam logic [3:0] CMD_NOP   = 4'd0;
  localparam logic [3:0] CMD_CLEAR = 4'd1;
  localparam logic [3:0] CMD_HOME  = 4'd2;
  localparam logic [3:0] CMD_ENTRY = 4'd3;
  localparam logic [3:0] CMD_DISP  = 4'd4;
  localparam logic [3:0] CMD_SHIFT = 4'd5;
  localparam logic [3:0] CMD_FUNC  = 4'd6;
  localparam logic [3:0] CMD_CGRAM = 4'd7;
  localparam logic [3:0] CMD_DDRAM = 4'd8;
  localparam logic [3:0] CMD_DATA  = 4'd9;

  logic          rs_meta, rs_sync;
  logic          en_meta, en_sync, en_prev;
  logic [7:0]    data_meta, data_sync;
  logic [CW-1:0] busy_cnt;

  logic          en_fall, busy_last, accept, reject;
  logic [3:0]    cmd;
  logic          load_busy;
  logic [CW-1:0] load_val;
  logic [6:0]    ac_inc, ac_dec, ac_step, ac_shift;
  logic          cell_row0, cell_row1;
  logic [6:0]    cell_lsb;

  // Address counter step, skipping the hidden gap between the two DDRAM lines.
  function automatic logic [6:0] step_ac(input logic [6:0] a, input logic up);
    logic [6:0] r;
    if (up) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h40)      r = 7'h27;
      else if (a == 7'h00) r = 7'h67;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  // Host pins are asynchronous; EN gets a third stage for edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rs_meta   <= 1'b0;
      rs_sync   <= 1'b0;
      en_meta   <= 1'b0;
      en_sync   <= 1'b0;
      en_prev   <= 1'b0;
      data_meta <= 8'h00;
      data_sync <= 8'h00;
    end else begin
      rs_meta   <= RS;
      rs_sync   <= rs_meta;
      en_meta   <= EN;
      en_sync   <= en_meta;
      en_prev   <= en_sync;
      data_meta <= DATA;
      data_sync <= data_meta;
    end
  end

  // A write landing on the final busy cycle is accepted, so back-to-back
  // host writes at exactly the busy period never see an error.
  assign en_fall   = en_prev & ~en_sync;
  assign busy_last = busy && (busy_cnt == '0);
  assign accept    = en_fall && (!busy || busy_last);
  assign reject    = en_fall && busy && !busy_last;

  always_comb begin
    cmd = CMD_NOP;
    if (rs_sync) begin
      cmd = CMD_DATA;
    end else begin
      casez (data_sync)
        8'b1???????: cmd = CMD_DDRAM;
        8'b01??????: cmd = CMD_CGRAM;
        8'b001?????: cmd = CMD_FUNC;
        8'b0001????: cmd = CMD_SHIFT;
        8'b00001???: cmd = CMD_DISP;
        8'b000001??: cmd = CMD_ENTRY;
        8'b0000001?: cmd = CMD_HOME;
        8'b00000001: cmd = CMD_CLEAR;
        default:     cmd = CMD_NOP;
      endcase
    end
  end

  always_comb begin
    load_busy = 1'b1;
    load_val  = LOAD_SHORT;
    case (cmd)
      CMD_NOP:             load_busy = 1'b0;
      CMD_CLEAR, CMD_HOME: load_val  = LOAD_LONG;
      default:             load_val  = LOAD_SHORT;
    endcase
  end

  assign ac_inc    = step_ac(addr, 1'b1);
  assign ac_dec    = step_ac(addr, 1'b0);
  assign ac_step   = inc_mode ? ac_inc : ac_dec;
  assign ac_shift  = data_sync[2] ? ac_inc : ac_dec;
  assign cell_row0 = (addr[6:4] == 3'b000);
  assign cell_row1 = (addr[6:4] == 3'b100);
  // Column 0 sits in the top byte of each row vector.
  assign cell_lsb  = {~addr[3:0], 3'b000};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      row0       <= BLANK_ROW;
      row1       <= BLANK_ROW;
      addr       <= 7'h00;
      busy       <= 1'b0;
      busy_cnt   <= '0;
      disp_on    <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      two_line   <= 1'b0;
      inc_mode   <= 1'b1;
      shift_mode <= 1'b0;
      wr_strobe  <= 1'b0;
      err_busy   <= 1'b0;
      err_mode   <= 1'b0;
    end else begin
      wr_strobe <= accept;
      if (reject) err_busy <= 1'b1;

      if (accept && load_busy) begin
        busy     <= 1'b1;
        busy_cnt <= load_val;
      end else if (busy) begin
        if (busy_cnt == '0) busy <= 1'b0;
        else                busy_cnt <= busy_cnt - 1'b1;
      end

      if (accept) begin
        case (cmd)
          CMD_DATA: begin
            if (cell_row0) row0[cell_lsb +: 8] <= data_sync;
            if (cell_row1) row1[cell_lsb +: 8] <= data_sync;
            addr <= ac_step;
          end
          CMD_CLEAR: begin
            row0     <= BLANK_ROW;
            row1     <= BLANK_ROW;
            addr     <= 7'h00;
            inc_mode <= 1'b1;
          end
          CMD_HOME: addr <= 7'h00;
          CMD_ENTRY: begin
            inc_mode   <= data_sync[1];
            shift_mode <= data_sync[0];
          end
          CMD_DISP: begin
            disp_on   <= data_sync[2];
            cursor_on <= data_sync[1];
            blink_on  <= data_sync[0];
          end
          CMD_SHIFT: begin
            if (!data_sync[3]) addr <= ac_shift;
          end
          CMD_FUNC: begin
            two_line <= data_sync[3];
            if (!data_sync[4]) err_mode <= 1'b1;
          end
          CMD_DDRAM: addr <= data_sync[6:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hd44780_responder.sv
// Self-checking bench for hd44780_responder: table-driven host writes checked
// through a strobe-driven scoreboard, plus busy, error and reset sequences.
module tb_hd44780_responder;

  localparam int T_SHORT = 8;
  localparam int T_LONG  = 40;
  localparam logic [127:0] BLANK_ROW = {16{8'h20}};

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         RS = 1'b0;
  logic         EN = 1'b0;
  logic [7:0]   DATA = 8'h00;
  logic [127:0] row0, row1;
  logic [6:0]   addr;
  logic         busy, disp_on, cursor_on, blink_on, two_line;
  logic         inc_mode, shift_mode, wr_strobe, err_busy, err_mode;
  logic [7:0]   flags;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    logic [6:0] exp_addr;
    logic [7:0] exp_flags;
    logic       exp_busy;
    logic [7:0] exp_r0c0;
    logic [7:0] exp_r1c0;
  } vec_t;

  vec_t scb[$];
  vec_t vecs[30];

  hd44780_responder #(.T_SHORT(T_SHORT), .T_LONG(T_LONG)) dut (
    .clk(clk), .reset_n(reset_n), .RS(RS), .EN(EN), .DATA(DATA),
    .row0(row0), .row1(row1), .addr(addr), .busy(busy),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .two_line(two_line), .inc_mode(inc_mode), .shift_mode(shift_mode),
    .wr_strobe(wr_strobe), .err_busy(err_busy), .err_mode(err_mode)
  );

  assign flags = {disp_on, cursor_on, blink_on, two_line, inc_mode, shift_mode, err_busy, err_mode};

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rs, input logic [7:0] d, input logic [6:0] a,
                              input logic [7:0] f, input logic b, input logic [7:0] r0,
                              input logic [7:0] r1);
    return {rs, d, a, f, b, r0, r1};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Every accepted write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    vec_t e;
    if (wr_strobe === 1'b1) begin
      if (scb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_strobe actual=1 expected=0 addr=%0h", addr);
      end else begin
        e = scb.pop_front();
        checkOutput($sformatf("w%02h_addr", e.data), 128'(addr), 128'(e.exp_addr));
        checkOutput($sformatf("w%02h_flags", e.data), 128'(flags), 128'(e.exp_flags));
        checkOutput($sformatf("w%02h_busy", e.data), 128'(busy), 128'(e.exp_busy));
        checkOutput($sformatf("w%02h_r0c0", e.data), 128'(row0[127:120]), 128'(e.exp_r0c0));
        checkOutput($sformatf("w%02h_r1c0", e.data), 128'(row1[127:120]), 128'(e.exp_r1c0));
      end
    end
  end

  task automatic drive_write(input logic rs_v, input logic [7:0] d, input int hi_cycles);
    @(negedge clk);
    RS   = rs_v;
    DATA = d;
    repeat (5) @(negedge clk);
    EN = 1'b1;
    repeat (hi_cycles) @(negedge clk);
    EN = 1'b0;
  endtask

  task automatic wait_strobe(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (wr_strobe === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    scb.push_back(v);
    drive_write(v.rs, v.data, 40);
    for (int i = 0; i < 12 && scb.size() != 0; i++) @(negedge clk);
    checkOutput($sformatf("w%02h_drain", v.data), 128'(scb.size()), 128'(0));
    scb.delete();
    repeat (10) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    checkOutput({tag, "_row0"}, row0, BLANK_ROW);
    checkOutput({tag, "_row1"}, row1, BLANK_ROW);
    checkOutput({tag, "_addr"}, 128'(addr), 128'(0));
    checkOutput({tag, "_busy"}, 128'(busy), 128'(0));
    checkOutput({tag, "_strobe"}, 128'(wr_strobe), 128'(0));
    checkOutput({tag, "_flags"}, 128'(flags), 128'(8'h08));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit           seen;
    int           busy_cycles;
    logic [127:0] pat;

    vecs[0]  = mk(1'b0, 8'h38, 7'h00, 8'h18, 1'b1, 8'h20, 8'h20);
    vecs[1]  = mk(1'b0, 8'h0C, 7'h00, 8'h98, 1'b1, 8'h20, 8'h20);
    vecs[2]  = mk(1'b0, 8'h01, 7'h00, 8'h98, 1'b1, 8'h20, 8'h20);
    vecs[3]  = mk(1'b0, 8'h06, 7'h00, 8'h98, 1'b1, 8'h20, 8'h20);
    vecs[4]  = mk(1'b0, 8'h80, 7'h00, 8'h98, 1'b1, 8'h20, 8'h20);
    vecs[5]  = mk(1'b1, 8'h48, 7'h01, 8'h98, 1'b1, 8'h48, 8'h20);
    vecs[6]  = mk(1'b1, 8'h45, 7'h02, 8'h98, 1'b1, 8'h48, 8'h20);
    vecs[7]  = mk(1'b1, 8'h4C, 7'h03, 8'h98, 1'b1, 8'h48, 8'h20);
    vecs[8]  = mk(1'b1, 8'h4C, 7'h04, 8'h98, 1'b1, 8'h48, 8'h20);
    vecs[9]  = mk(1'b1, 8'h4F, 7'h05, 8'h98, 1'b1, 8'h48, 8'h20);
    vecs[10] = mk(1'b0, 8'hC0, 7'h40, 8'h98, 1'b1, 8'h48, 8'h20);
    vecs[11] = mk(1'b1, 8'h41, 7'h41, 8'h98, 1'b1, 8'h48, 8'h41);
    vecs[12] = mk(1'b0, 8'hA7, 7'h27, 8'h98, 1'b1, 8'h48, 8'h41);
    vecs[13] = mk(1'b1, 8'h58, 7'h40, 8'h98, 1'b1, 8'h48, 8'h41);
    vecs[14] = mk(1'b0, 8'h04, 7'h40, 8'h90, 1'b1, 8'h48, 8'h41);
    vecs[15] = mk(1'b1, 8'h59, 7'h27, 8'h90, 1'b1, 8'h48, 8'h59);
    vecs[16] = mk(1'b0, 8'h14, 7'h40, 8'h90, 1'b1, 8'h48, 8'h59);
    vecs[17] = mk(1'b0, 8'h10, 7'h27, 8'h90, 1'b1, 8'h48, 8'h59);
    vecs[18] = mk(1'b0, 8'h18, 7'h27, 8'h90, 1'b1, 8'h48, 8'h59);
    vecs[19] = mk(1'b0, 8'h0F, 7'h27, 8'hF0, 1'b1, 8'h48, 8'h59);
    vecs[20] = mk(1'b0, 8'h00, 7'h27, 8'hF0, 1'b0, 8'h48, 8'h59);
    vecs[21] = mk(1'b0, 8'h40, 7'h27, 8'hF0, 1'b1, 8'h48, 8'h59);
    vecs[22] = mk(1'b0, 8'h02, 7'h00, 8'hF0, 1'b1, 8'h48, 8'h59);
    vecs[23] = mk(1'b0, 8'h06, 7'h00, 8'hF8, 1'b1, 8'h48, 8'h59);
    vecs[24] = mk(1'b0, 8'hE7, 7'h67, 8'hF8, 1'b1, 8'h48, 8'h59);
    vecs[25] = mk(1'b1, 8'h5A, 7'h00, 8'hF8, 1'b1, 8'h48, 8'h59);
    vecs[26] = mk(1'b0, 8'h04, 7'h00, 8'hF0, 1'b1, 8'h48, 8'h59);
    vecs[27] = mk(1'b0, 8'h10, 7'h67, 8'hF0, 1'b1, 8'h48, 8'h59);
    vecs[28] = mk(1'b0, 8'h06, 7'h67, 8'hF8, 1'b1, 8'h48, 8'h59);
    vecs[29] = mk(1'b0, 8'h80, 7'h00, 8'hF8, 1'b1, 8'h48, 8'h59);

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_state("por");

    for (int i = 0; i < 30; i++) applyStimulus(vecs[i]);
    checkOutput("hello_row0", row0, {8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, {11{8'h20}}});
    checkOutput("hello_row1", row1, {8'h59, {15{8'h20}}});

    // Clear, then a second write arrives while its long busy is running.
    scb.push_back(mk(1'b0, 8'h01, 7'h00, 8'hF8, 1'b1, 8'h20, 8'h20));
    drive_write(1'b0, 8'h01, 40);
    wait_strobe(seen);
    checkOutput("clr_detect", 128'(seen), 128'(1));
    busy_cycles = 0;
    fork
      begin
        for (int i = 0; i < 200 && busy === 1'b1; i++) begin
          busy_cycles++;
          @(negedge clk);
        end
      end
      begin
        RS   = 1'b1;
        DATA = 8'h5A;
        EN   = 1'b1;
        repeat (7) @(negedge clk);
        EN = 1'b0;
        repeat (5) @(negedge clk);
      end
    join
    checkOutput("clr_busy_len", 128'(busy_cycles), 128'(T_LONG));
    checkOutput("clr_err_busy", 128'(err_busy), 128'(1));
    checkOutput("clr_addr", 128'(addr), 128'(0));
    checkOutput("clr_row0", row0, BLANK_ROW);
    checkOutput("clr_row1", row1, BLANK_ROW);
    scb.delete();
    repeat (10) @(negedge clk);

    applyStimulus(mk(1'b0, 8'h28, 7'h00, 8'hFB, 1'b1, 8'h20, 8'h20));
    applyStimulus(mk(1'b0, 8'h80, 7'h00, 8'hFB, 1'b1, 8'h20, 8'h20));
    applyStimulus(mk(1'b1, 8'h5A, 7'h01, 8'hFB, 1'b1, 8'h5A, 8'h20));

    // Reset on the strobe cycle of a data write, with its busy still running.
    scb.push_back(mk(1'b1, 8'h59, 7'h02, 8'hFB, 1'b1, 8'h5A, 8'h20));
    drive_write(1'b1, 8'h59, 40);
    wait_strobe(seen);
    checkOutput("rst_detect", 128'(seen), 128'(1));
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_reset_state("midrst");
    repeat (3) @(negedge clk);
    checkOutput("midrst_busy_late", 128'(busy), 128'(0));
    scb.delete();

    pat = "0123456789ABCDEF";
    applyStimulus(mk(1'b0, 8'h80, 7'h00, 8'h08, 1'b1, 8'h20, 8'h20));
    for (int i = 0; i < 16; i++)
      applyStimulus(mk(1'b1, pat[127-8*i -: 8], 7'(i + 1), 8'h08, 1'b1, 8'h30, 8'h20));
    checkOutput("loop_row0", row0, pat);
    checkOutput("loop_row1", row1, BLANK_ROW);
    checkOutput("loop_addr", 128'(addr), 128'(7'h10));
    checkOutput("loop_err_busy", 128'(err_busy), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
